// File: rtl/gate_selftest.sv
// gate_selftest: on-chip response checker for a two-input basic-gate block.
// Drives the four {a,b} vectors in order 00,01,10,11, holds each for SETTLE
// cycles, then compares the six gate responses against the truth table.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 begin a run (honoured in IDLE or DONE only)
//   a, b                  stimulus to the gate block (a is the vector MSB)
//   p,q,r,s,t,u           responses: AND, OR, XOR, NAND, NOR, XNOR
//   busy, done, pass      run status; pass = done && err_cnt == 0
//   err_cnt               number of failing vectors (saturating)
//   fail_vec, fail_mask   {a,b} and {p..u} mismatch bits of the first failure
module gate_selftest #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             p,
  input  logic             q,
  input  logic             r,
  input  logic             s,
  input  logic             t,
  input  logic             u,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic [5:0]       fail_mask
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [1:0]       vec_q;     // vector index; also the driven {a,b}
  logic [CW-1:0]    cnt_q;     // settle counter within the current vector
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic [1:0]       fvec_q;
  logic [5:0]       fmask_q;

  logic             va, vb;
  logic [5:0]       exp_d, mask_d;
  logic [ERR_W-1:0] err_d;
  logic             fail_d, first_d;

  // Responses are combinational on the driven vector, so compare directly.
  always_comb begin
    va      = vec_q[1];
    vb      = vec_q[0];
    exp_d   = {va & vb, va | vb, va ^ vb, ~(va & vb), ~(va | vb), ~(va ^ vb)};
    mask_d  = exp_d ^ {p, q, r, s, t, u};
    fail_d  = |mask_d;
    // err_cnt never returns to 0 within a run (saturates), so zero means
    // no failure has been recorded yet.
    first_d = fail_d && (err_q == '0);
    err_d   = err_q;
    if (fail_d && !(&err_q)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 2'b00;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= 2'b00;
      fmask_q <= 6'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            vec_q   <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= 2'b00;
            fmask_q <= 6'b0;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            // Sampling edge: record this vector, launch the next one.
            cnt_q <= '0;
            err_q <= err_d;
            if (first_d) begin
              fvec_q  <= vec_q;
              fmask_q <= mask_d;
            end
            if (vec_q == 2'b11) begin
              state_q <= DONE;
              vec_q   <= 2'b00;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + 2'b01;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_vec  = fvec_q;
  assign fail_mask = fmask_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Directed bench for gate_selftest: one checker with SETTLE=1 fed by a gate
// model with selectable faults, one with SETTLE=3 fed by a correct model.
module tb_gate_selftest;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3;
  int   fault;  // 0 correct, 1 OR stuck at 0, 2 XOR/XNOR swapped

  // SETTLE=1 instance
  logic a1, b1, p1, q1, r1, s1, t1, u1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] fv1;
  logic [5:0] fm1;

  // SETTLE=3 instance
  logic a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [1:0] fv3;
  logic [5:0] fm3;

  always_comb begin
    p1 = a1 & b1;
    q1 = (fault == 1) ? 1'b0 : (a1 | b1);
    r1 = (fault == 2) ? ~(a1 ^ b1) : (a1 ^ b1);
    s1 = ~(a1 & b1);
    t1 = ~(a1 | b1);
    u1 = (fault == 2) ? (a1 ^ b1) : ~(a1 ^ b1);
  end

  gate_selftest #(.SETTLE(1), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .p(p1), .q(q1), .r(r1), .s(s1), .t(t1), .u(u1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fv1), .fail_mask(fm1));

  gate_selftest #(.SETTLE(3), .ERR_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .p(a3 & b3), .q(a3 | b3), .r(a3 ^ b3), .s(~(a3 & b3)), .t(~(a3 | b3)),
    .u(~(a3 ^ b3)),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_vec(fv3), .fail_mask(fm3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start1 for the next edge (E0); returns just after E0 (at negedge).
  task automatic kick1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // After E0 has been seen: check vectors at E0..E3 and the result at E4.
  task automatic run_rest1(input string nm, input logic [2:0] e_err,
                           input logic [1:0] e_fv, input logic [5:0] e_fm);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk({nm, " vec"}, {a1, b1}, k[1:0]);
      chk({nm, " busy"}, busy1, 1'b1);
    end
    @(negedge clk);
    chk({nm, " done"}, done1, 1'b1);
    chk({nm, " busy_end"}, busy1, 1'b0);
    chk({nm, " ab_end"}, {a1, b1}, 2'b00);
    chk({nm, " err"}, err1, e_err);
    chk({nm, " fvec"}, fv1, e_fv);
    chk({nm, " fmask"}, fm1, e_fm);
    chk({nm, " pass"}, pass1, e_err == 3'd0);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; fault = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst ab", {a1, b1}, 2'b00);
    chk("rst status", {busy1, done1, pass1}, 3'b000);
    chk("rst results", {err1, fv1, fm1}, 11'd0);
    chk("rst dut3", {a3, b3, busy3, done3, pass3, err3}, 8'd0);

    // 1: correct model
    kick1();
    run_rest1("good", 3'd0, 2'b00, 6'b0);

    // 2: OR stuck at 0, started from DONE -> results cleared on start edge
    fault = 1;
    kick1();
    chk("restart done", done1, 1'b0);
    chk("restart busy", busy1, 1'b1);
    run_rest1("qstuck", 3'd3, 2'b01, 6'b010000);

    // 3: XOR/XNOR swapped
    fault = 2;
    kick1();
    chk("clr err", err1, 3'd0);
    chk("clr fail", {fv1, fm1}, 8'd0);
    run_rest1("swap", 3'd4, 2'b00, 6'b001001);

    // 4: fault removed, rerun passes
    fault = 0;
    kick1();
    chk("clr2 err", err1, 3'd0);
    chk("clr2 pass", pass1, 1'b0);
    run_rest1("rerun", 3'd0, 2'b00, 6'b0);

    // 5: start pulsed mid-run (sampled at E2) is ignored
    kick1();                       // at E0
    @(negedge clk);                // E1
    start1 = 1'b1;
    @(negedge clk);                // E2
    start1 = 1'b0;
    chk("mid vec E2", {a1, b1}, 2'b10);
    @(negedge clk);                // E3
    chk("mid vec E3", {a1, b1}, 2'b11);
    chk("mid done E3", done1, 1'b0);
    @(negedge clk);                // E4
    chk("mid done E4", done1, 1'b1);
    chk("mid pass", pass1, 1'b1);

    // 6: rst during a run discards everything
    fault = 1;
    kick1();                       // E0
    @(negedge clk);                // E1
    @(negedge clk);                // E2
    rst = 1'b1;
    @(negedge clk);                // E3 samples rst
    rst = 1'b0;
    chk("rstmid ab", {a1, b1}, 2'b00);
    chk("rstmid status", {busy1, done1, pass1}, 3'b000);
    chk("rstmid results", {err1, fv1, fm1}, 11'd0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("rstmid no done", {done1, busy1}, 2'b00);
    fault = 0;

    // 7: rst and start on the same edge -> rst wins
    rst = 1'b1; start1 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0;
    chk("rst+start", {busy1, done1, a1, b1}, 4'b0000);

    // 8: SETTLE=3 timing
    begin
      logic [1:0] e_vec;
      int busy_cnt;
      busy_cnt = 0;
      start3 = 1'b1;
      @(negedge clk);              // E0
      start3 = 1'b0;
      for (int k = 0; k <= 12; k++) begin
        if (k > 0) @(negedge clk);
        if (busy3) busy_cnt++;
        e_vec = (k >= 12) ? 2'b00 : 2'(k / 3);
        chk($sformatf("s3 vec E%0d", k), {a3, b3}, e_vec);
        chk($sformatf("s3 done E%0d", k), done3, k == 12);
      end
      chk("s3 busy cycles", busy_cnt, 12);
      chk("s3 pass", pass3, 1'b1);
      chk("s3 results", {err3, fv3, fm3}, 11'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_selftest.md
# gate_selftest

On-chip response checker for the two-input basic-gate block; it works on the opposite side of the gate interface from the stimulus bench. When triggered, it drives the four input vectors onto `a`/`b` and samples the six gate outputs after a programmable settle time. Each sample is compared against the internally computed truth table. It reports an error count, the first failing vector and mismatch mask, and a pass/done status, so gate correctness can be checked in hardware without a simulator monitor.

## Interface
- `SETTLE`, default 1: cycles each vector is held before its responses are sampled; legal range ≥1.
- `ERR_W`, default 3: width of the error counter; legal range ≥3.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a test run; acted on only in IDLE or DONE.
- `a`, `b` out 1 each: stimulus to the gate block; `a` is the vector MSB.
- `p`, `q`, `r`, `s`, `t`, `u` in 1 each: gate responses, in the order AND, OR, XOR, NAND, NOR, XNOR.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next `start` or `rst`.
- `pass` out 1: `done` && `err_cnt` == 0.
- `err_cnt` out ERR_W: number of failing vectors; saturates at all-ones.
- `fail_vec` out 2: {a,b} of the first failing vector; 0 if there is none.
- `fail_mask` out 6: {p..u} mismatch bits of the first failing vector; 0 if there is none.

## Operation
- States:
  - IDLE: `a`=`b`=0, `busy`=0, `done`=0.
  - RUN: applies vectors.
  - DONE: `a`=`b`=0, `done`=1.
- Transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DONE after vector 3 is checked.
  - DONE -> RUN on `start`.
  - Any state -> IDLE on `rst`.
- Vector order: 00, 01, 10, 11, held in a 2-bit index; no wrap past 11.
- Expected response: {a&b, a|b, a^b, ~(a&b), ~(a|b), ~(a^b)}.
- Mismatch: mask = expected XOR {p,q,r,s,t,u}. Any nonzero mask counts as one failing vector, so `err_cnt` is incremented by at most 1 per vector.
- First failure: `fail_vec`/`fail_mask` are captured only on the first nonzero mask of a run and are not overwritten by later failures.
- `start` in RUN is ignored.
- A `start` that enters RUN clears `err_cnt`, `fail_vec`, `fail_mask` and `done` on the same edge.
- The responses are combinational functions of `a`/`b`, so no input registering is required. `SETTLE` covers any external pipelining.

## Timing
- Reset values: `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `fail_mask`=0, state IDLE, settle counter 0.
- Edge E0 samples `start`=1. At E0, `a`/`b` become 00 and `busy`=1.
- Vector k is driven at edge E0+k·SETTLE and its responses are sampled at edge E0+(k+1)·SETTLE.
- At each sampling edge the next vector is driven, so there are no idle cycles between vectors.
- At edge E0+4·SETTLE:
  - final check;
  - `busy`=0, `done`=1;
  - `a`=`b`=0;
  - `err_cnt`/`fail_*` already include vector 3;
  - `pass` is valid on that edge.
- Run length is 4·SETTLE cycles.
- Restart from DONE: `start` at edge E1 drops `done` and raises `busy` on E1.
- `rst` mid-run: on the next edge all outputs return to reset values and any partial results are discarded.
- `rst` and `start` on the same edge: `rst` wins.
- Saturation: with ERR_W ≥ 3 and 4 vectors, `err_cnt` cannot saturate. The saturation logic is still required for any ERR_W.

## Test plan
- Correct gate model, SETTLE=1, `start` at edge 0 -> `a`/`b` = 00, 01, 10, 11 at edges 0–3; `done`=1, `pass`=1, `err_cnt`=0, `fail_mask`=0 at edge 4.
- `q` stuck at 0 -> `err_cnt`=3, `fail_vec`=01, `fail_mask`=6'b010000, `pass`=0.
- XOR and XNOR outputs swapped -> `err_cnt`=4, `fail_vec`=00, `fail_mask`=6'b001001.
- SETTLE=3 with correct model -> vector changes at edges 0, 3, 6, 9; `done` at edge 12; `busy` high for exactly 12 cycles.
- `start` pulsed at edge 2 mid-run -> no effect, `done` still at edge 4. Separately, `rst` at edge 2 -> all outputs 0 at edge 3 and no `done`.
- Fault run followed by `start` in DONE with fault removed -> `err_cnt`/`fail_*` cleared on the start edge; second run ends with `pass`=1.
